// File: rtl/shift_right_seq.sv
// Sequential multi-mode right shifter: one bit per clock for a captured count.
// Supports logical, arithmetic, rotate and serial-in fill, with a start/busy/done handshake.
module shift_right_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_din,
  input  logic [CNT_W-1:0] i_amt,
  input  logic [1:0]       i_mode,
  input  logic             i_sin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_cout
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [1:0] ModeLogical = 2'b00;
  localparam logic [1:0] ModeArith   = 2'b01;
  localparam logic [1:0] ModeRotate  = 2'b10;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_dout_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_next;
  logic             r_cout;
  logic             w_cout_next;
  logic             w_accept;
  logic             w_fill;

  // Start is only honoured when no shift is in flight; DONE allows back-to-back.
  assign w_accept = i_start && (r_state != StShift);

  always_comb begin
    w_fill = 1'b0;
    case (r_mode)
      ModeLogical: w_fill = 1'b0;
      ModeArith:   w_fill = r_dout[WIDTH-1];
      ModeRotate:  w_fill = r_dout[0];
      default:     w_fill = i_sin;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_dout_next  = r_dout;
    w_cnt_next   = r_cnt;
    w_mode_next  = r_mode;
    w_cout_next  = r_cout;
    case (r_state)
      StIdle, StDone: begin
        if (w_accept) begin
          w_dout_next  = i_din;
          w_cnt_next   = i_amt;
          w_mode_next  = i_mode;
          w_cout_next  = 1'b0;
          w_state_next = (i_amt != '0) ? StShift : StDone;
        end else begin
          w_state_next = StIdle;
        end
      end
      StShift: begin
        w_cout_next = r_dout[0];
        w_dout_next = {w_fill, r_dout[WIDTH-1:1]};
        w_cnt_next  = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = StDone;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_dout  <= '0;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_dout  <= w_dout_next;
      r_cnt   <= w_cnt_next;
      r_mode  <= w_mode_next;
      r_cout  <= w_cout_next;
    end
  end

  assign o_busy = (r_state == StShift);
  assign o_done = (r_state == StDone);
  assign o_dout = r_dout;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: directed cases with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_shift_right_seq;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst, start, sin;
  logic [3:0] din;
  logic [2:0] amt;
  logic [1:0] mode;
  logic       busy, done, cout;
  logic [3:0] dout;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  shift_right_seq #(.WIDTH(4), .CNT_W(3)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_din  (din),
    .i_amt  (amt),
    .i_mode (mode),
    .i_sin  (sin),
    .o_busy (busy),
    .o_done (done),
    .o_dout (dout),
    .o_cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an operation is a window of amt shift cycles followed by one done cycle.
  // The result is the low W bits of a wide vector {fills..., din} shifted right by amt.
  logic        m_act = 1'b0;
  int          m_k = 0, m_amt = 0;
  logic [1:0]  m_mode = '0;
  logic [3:0]  m_din = '0;
  logic [63:0] m_big = '0;
  logic        exp_busy = 1'b0, exp_done = 1'b0, exp_cout = 1'b0;
  logic [3:0]  exp_dout = '0;

  always @(posedge clk) begin : model
    logic act, rc;
    int k, a, r;
    logic [1:0] md;
    logic [3:0] d, rd;
    logic [7:0] dd;
    logic [63:0] big, sh;
    act = m_act; k = m_k; a = m_amt; md = m_mode; d = m_din; big = m_big;
    rd = exp_dout; rc = exp_cout;
    if (rst) begin
      act = 1'b0; rd = '0; rc = 1'b0;
    end else begin
      if (act && k < a) begin
        k++;
        if (md == 2'b11) big[W-1+k] = sin;
      end else if (start) begin
        act = 1'b1; k = 0; a = int'(amt); md = mode; d = din;
        big = 64'(din);
        if (mode == 2'b01) for (int i = 0; i < a; i++) big[W+i] = din[W-1];
      end else begin
        act = 1'b0;
      end
      if (act && k == a) begin
        if (md == 2'b10) begin
          r  = a % W;
          dd = {d, d} >> r;
          rd = dd[3:0];
          rc = (a == 0) ? 1'b0 : d[(a-1) % W];
        end else begin
          sh = big >> a;
          rd = sh[3:0];
          rc = (a == 0) ? 1'b0 : big[a-1];
        end
      end
    end
    m_act    <= act;
    m_k      <= k;
    m_amt    <= a;
    m_mode   <= md;
    m_din    <= d;
    m_big    <= big;
    exp_busy <= act && (k < a);
    exp_done <= act && (k == a);
    exp_dout <= rd;
    exp_cout <= rc;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 32'(busy), 32'(exp_busy));
      check("model_done", 32'(done), 32'(exp_done));
      if (!exp_busy) begin
        check("model_dout", 32'(dout), 32'(exp_dout));
        check("model_cout", 32'(cout), 32'(exp_cout));
      end
    end
  end

  // Called right after a negedge; returns at the negedge where done is seen.
  task automatic do_op(input string nm, input logic [3:0] d, input logic [2:0] a,
                       input logic [1:0] m, input logic [3:0] sins, input int poke,
                       input logic [3:0] exp_d, input logic exp_c);
    int n, busy_n;
    logic seen;
    n = 0; busy_n = 0; seen = 1'b0;
    start = 1'b1; din = d; amt = a; mode = m; sin = $urandom_range(0, 1);
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      start = (poke != 0 && n == poke);
      din   = (start) ? 4'b0101 : 4'($urandom);
      amt   = 3'($urandom);
      mode  = 2'($urandom);
      sin   = (n <= 4) ? sins[n-1] : 1'($urandom_range(0, 1));
      if (busy) busy_n++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({nm, "_seen_done"}, 32'(seen), 32'd1);
    check({nm, "_latency"}, 32'(n), 32'(int'(a) + 1));
    check({nm, "_busy_cycles"}, 32'(busy_n), 32'(a));
    check({nm, "_dout"}, 32'(dout), 32'(exp_d));
    check({nm, "_cout"}, 32'(cout), 32'(exp_c));
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic saw_done;
    rst = 1'b1; start = 1'b0; din = '0; amt = '0; mode = '0; sin = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    // Reset in the third shift cycle of a long operation.
    start = 1'b1; din = 4'b1111; amt = 3'd7; mode = 2'b00;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midop_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midop_rst_busy", 32'(busy), 32'd0);
    check("midop_rst_dout", 32'(dout), 32'd0);
    check("midop_rst_cout", 32'(cout), 32'd0);
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("midop_no_done", 32'(saw_done), 32'd0);

    do_op("logical",  4'b1001, 3'd3, 2'b00, 4'b0000, 0, 4'b0001, 1'b0);
    idle(2);
    do_op("arith",    4'b1010, 3'd2, 2'b01, 4'b0000, 0, 4'b1110, 1'b1);
    idle(1);
    do_op("rotate",   4'b1011, 3'd1, 2'b10, 4'b0000, 0, 4'b1101, 1'b1);
    idle(1);
    do_op("zero_amt", 4'b0110, 3'd0, 2'b00, 4'b0000, 0, 4'b0110, 1'b0);
    idle(1);
    do_op("serial",   4'b0000, 3'd4, 2'b11, 4'b1101, 0, 4'b1101, 1'b0);
    idle(1);
    do_op("ignore_start", 4'b1000, 3'd3, 2'b00, 4'b0000, 2, 4'b0001, 1'b0);
    // Consecutive calls start in the DONE cycle of the previous operation.
    do_op("b2b_first",  4'b1100, 3'd2, 2'b00, 4'b0000, 0, 4'b0011, 1'b0);
    do_op("b2b_second", 4'b0111, 3'd1, 2'b10, 4'b0000, 0, 4'b1011, 1'b1);
    idle(1);
    do_op("sat_arith",  4'b1000, 3'd7, 2'b01, 4'b0000, 0, 4'b1111, 1'b1);
    do_op("sat_logic",  4'b1000, 3'd7, 2'b00, 4'b0000, 0, 4'b0000, 1'b0);
    do_op("sat_rotate", 4'b1000, 3'd7, 2'b10, 4'b0000, 0, 4'b0001, 1'b0);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) != 0);
      din   = 4'($urandom);
      amt   = 3'($urandom);
      mode  = 2'($urandom);
      sin   = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
